oflow_fe_scheduler: RTL and testbench

//  Shares one oflow_features_extraction (FE) instance between NUM_REQ bbox sources, frame by frame.

---
 rtl/oflow_fe_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_oflow_fe_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_fe_scheduler.sv
// oflow_fe_scheduler: round-robin sharing of one feature-extraction unit between NUM_REQ bbox sources.
// Optional macro OFLOW_FE_SCHED_PERF_EN adds the stall_cycles output (RUN cycles without an issue).
`ifndef BBOX_VECTOR_SIZE
`define BBOX_VECTOR_SIZE 32
`endif

module oflow_fe_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int BBOX_W     = `BBOX_VECTOR_SIZE,
    parameter int FE_LATENCY = 2,
    parameter int MAX_OBJ    = 64,
    localparam int OBJ_W     = $clog2(MAX_OBJ + 1),
    localparam int RID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_N,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*BBOX_W-1:0] req_bbox,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fe_enable,
    output logic [BBOX_W-1:0]         fe_bbox,
    output logic                      res_valid,
    output logic [RID_W-1:0]          res_req_id,
    output logic [OBJ_W-1:0]          res_obj_idx,
    output logic [OBJ_W-1:0]          obj_count,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overflow
`ifdef OFLOW_FE_SCHED_PERF_EN
    ,
    output logic [15:0]               stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [RID_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] last_seen;

    logic               can_grant;
    logic [NUM_REQ-1:0] eligible;
    logic               xfer;
    logic [RID_W-1:0]   gnt_id;
    logic [RID_W:0]     cand_sum;
    logic [RID_W-1:0]   cand;
    logic [NUM_REQ-1:0] last_seen_nxt;
    logic [OBJ_W-1:0]   obj_count_nxt;
    logic               all_last_nxt;
    logic               max_hit_nxt;
    logic               pipe_busy;

    logic [BBOX_W-1:0]  bbox_arr [NUM_REQ];

    // Tag pipe: stage k holds the tag of the object issued k+1 cycles ago.
    logic               vld_p [FE_LATENCY+1];
    logic [RID_W-1:0]   id_p  [FE_LATENCY+1];
    logic [OBJ_W-1:0]   idx_p [FE_LATENCY+1];

    function automatic logic [OBJ_W-1:0] sat_inc_obj(input logic [OBJ_W-1:0] v);
        return (v == OBJ_W'(MAX_OBJ)) ? v : v + OBJ_W'(1);
    endfunction

    function automatic logic [RID_W-1:0] wrap_inc_id(input logic [RID_W-1:0] v);
        return (v == RID_W'(NUM_REQ - 1)) ? '0 : v + RID_W'(1);
    endfunction

`ifdef OFLOW_FE_SCHED_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign bbox_arr[i] = req_bbox[i*BBOX_W +: BBOX_W];
    end

    // Round-robin search starting at rr_ptr; grant never looks at req_ready.
    always_comb begin
        can_grant = (state == RUN) && (obj_count < OBJ_W'(MAX_OBJ));
        eligible  = can_grant ? (req_valid & ~last_seen) : '0;
        req_ready = '0;
        xfer      = 1'b0;
        gnt_id    = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (RID_W+1)'(k);
            if (cand_sum >= (RID_W+1)'(NUM_REQ))
                cand_sum = cand_sum - (RID_W+1)'(NUM_REQ);
            cand = cand_sum[RID_W-1:0];
            if (!xfer && eligible[cand]) begin
                xfer   = 1'b1;
                gnt_id = cand;
            end
        end
        req_ready[gnt_id] = xfer;
    end

    always_comb begin
        last_seen_nxt = last_seen;
        if (xfer && req_last[gnt_id])
            last_seen_nxt[gnt_id] = 1'b1;
        obj_count_nxt = xfer ? sat_inc_obj(obj_count) : obj_count;
        all_last_nxt  = &last_seen_nxt;
        max_hit_nxt   = (obj_count_nxt == OBJ_W'(MAX_OBJ));
        pipe_busy     = 1'b0;
        // The last stage is being delivered this cycle, so it no longer counts as in flight.
        for (int k = 0; k < FE_LATENCY; k++)
            pipe_busy = pipe_busy | vld_p[k];
    end

    always_ff @(posedge clk) begin
        if (reset_N) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            last_seen  <= '0;
            obj_count  <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            fe_enable  <= 1'b0;
            fe_bbox    <= '0;
        end else begin
            frame_done <= 1'b0;
            fe_enable  <= xfer;
            if (xfer) begin
                fe_bbox   <= bbox_arr[gnt_id];
                rr_ptr    <= wrap_inc_id(gnt_id);
                obj_count <= obj_count_nxt;
                last_seen <= last_seen_nxt;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        obj_count <= '0;
                        last_seen <= '0;
                        overflow  <= 1'b0;
                    end
                end
                RUN: begin
                    if (all_last_nxt || max_hit_nxt) begin
                        state    <= DRAIN;
                        overflow <= max_hit_nxt && !all_last_nxt;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue stage -> tag pipe stages 0..FE_LATENCY
    always_ff @(posedge clk) begin
        if (reset_N) begin
            for (int k = 0; k <= FE_LATENCY; k++) begin
                vld_p[k] <= 1'b0;
                id_p[k]  <= '0;
                idx_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= xfer;
            id_p[0]  <= gnt_id;
            idx_p[0] <= obj_count;
            for (int k = 1; k <= FE_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
                id_p[k]  <= id_p[k-1];
                idx_p[k] <= idx_p[k-1];
            end
        end
    end

    assign res_valid   = vld_p[FE_LATENCY];
    assign res_req_id  = id_p[FE_LATENCY];
    assign res_obj_idx = idx_p[FE_LATENCY];

`ifdef OFLOW_FE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset_N)
            stall_cycles <= '0;
        else if (state == IDLE && frame_start)
            stall_cycles <= '0;
        else if (state == RUN && !xfer)
            stall_cycles <= sat_inc16(stall_cycles);
    end
`endif

endmodule

// File: tb/tb_oflow_fe_scheduler.sv
// Self-checking bench for oflow_fe_scheduler: per-cycle vector table plus a due-cycle scoreboard
// for fe issues, tagged results and frame_done pulses.
module tb_oflow_fe_scheduler;
    localparam int NR   = 4;
    localparam int BW   = 32;
    localparam int LAT  = 2;
    localparam int MAXO = 8;
    localparam int OW   = $clog2(MAXO + 1);
    localparam int RW   = $clog2(NR);

    logic             clk = 1'b0;
    logic             reset_N;
    logic             frame_start;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_last;
    logic [NR*BW-1:0] req_bbox;
    logic [NR-1:0]    req_ready;
    logic             fe_enable;
    logic [BW-1:0]    fe_bbox;
    logic             res_valid;
    logic [RW-1:0]    res_req_id;
    logic [OW-1:0]    res_obj_idx;
    logic [OW-1:0]    obj_count;
    logic             busy;
    logic             frame_done;
    logic             overflow;
`ifdef OFLOW_FE_SCHED_PERF_EN
    logic [15:0]      stall_cycles;
`endif

    always #5 clk = ~clk;

    oflow_fe_scheduler #(
        .NUM_REQ(NR), .BBOX_W(BW), .FE_LATENCY(LAT), .MAX_OBJ(MAXO)
    ) dut (
        .clk(clk), .reset_N(reset_N), .frame_start(frame_start),
        .req_valid(req_valid), .req_last(req_last), .req_bbox(req_bbox),
        .req_ready(req_ready), .fe_enable(fe_enable), .fe_bbox(fe_bbox),
        .res_valid(res_valid), .res_req_id(res_req_id), .res_obj_idx(res_obj_idx),
        .obj_count(obj_count), .busy(busy), .frame_done(frame_done), .overflow(overflow)
`ifdef OFLOW_FE_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic          fs;
        logic [NR-1:0] v;
        logic [NR-1:0] l;
        logic [NR-1:0] er;
        logic          fin;
        int            cnt;
        logic          ovf;
        logic          bsy;
    } row_t;

    typedef struct { int due; logic [BW-1:0] bbox; } fe_exp_t;
    typedef struct { int due; logic [RW-1:0] id; logic [OW-1:0] idx; } res_exp_t;

    row_t     tbl[$];
    fe_exp_t  fe_q[$];
    res_exp_t res_q[$];
    int       fd_q[$];
    int       ph[6];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       cyc   = 0;
    int       seq   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] bbox_of(input int i, input int s);
        return {8'(i + 1), 8'h5A, 16'(s)};
    endfunction

    task automatic drive_bbox();
        for (int i = 0; i < NR; i++) req_bbox[i*BW +: BW] = bbox_of(i, seq);
    endtask

    task automatic add(input logic fs, input logic [NR-1:0] v, input logic [NR-1:0] l,
                       input logic [NR-1:0] er, input logic fin, input int cnt,
                       input logic ovf, input logic bsy, input int rep = 1);
        row_t r;
        r.fs = fs; r.v = v; r.l = l; r.er = er; r.fin = fin;
        r.cnt = cnt; r.ovf = ovf; r.bsy = bsy;
        repeat (rep) tbl.push_back(r);
    endtask

    // Compares what is due this cycle against fe/res/frame_done outputs.
    task automatic monitor();
        logic e;
        e = (fe_q.size() > 0) && (fe_q[0].due == cyc);
        chk("fe_enable", 64'(fe_enable), 64'(e));
        if (e) begin
            chk("fe_bbox", 64'(fe_bbox), 64'(fe_q[0].bbox));
            fe_q.delete(0);
        end
        e = (res_q.size() > 0) && (res_q[0].due == cyc);
        chk("res_valid", 64'(res_valid), 64'(e));
        if (e) begin
            chk("res_req_id", 64'(res_req_id), 64'(res_q[0].id));
            chk("res_obj_idx", 64'(res_obj_idx), 64'(res_q[0].idx));
            res_q.delete(0);
        end
        e = (fd_q.size() > 0) && (fd_q[0] == cyc);
        chk("frame_done", 64'(frame_done), 64'(e));
        if (e) fd_q.delete(0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic purge_future();
        for (int i = fe_q.size() - 1; i >= 0; i--)  if (fe_q[i].due > cyc)  fe_q.delete(i);
        for (int i = res_q.size() - 1; i >= 0; i--) if (res_q[i].due > cyc) res_q.delete(i);
        for (int i = fd_q.size() - 1; i >= 0; i--)  if (fd_q[i] > cyc)      fd_q.delete(i);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, ".fe_enable"}, 64'(fe_enable), 64'(0));
        chk({tag, ".fe_bbox"}, 64'(fe_bbox), 64'(0));
        chk({tag, ".res_valid"}, 64'(res_valid), 64'(0));
        chk({tag, ".res_req_id"}, 64'(res_req_id), 64'(0));
        chk({tag, ".res_obj_idx"}, 64'(res_obj_idx), 64'(0));
        chk({tag, ".obj_count"}, 64'(obj_count), 64'(0));
        chk({tag, ".busy"}, 64'(busy), 64'(0));
        chk({tag, ".frame_done"}, 64'(frame_done), 64'(0));
        chk({tag, ".overflow"}, 64'(overflow), 64'(0));
`ifdef OFLOW_FE_SCHED_PERF_EN
        chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(0));
`endif
    endtask

    task automatic run_rows(input int lo, input int hi);
        int g;
        for (int i = lo; i < hi; i++) begin
            step();
            frame_start = tbl[i].fs;
            req_valid   = tbl[i].v;
            req_last    = tbl[i].l;
            seq++;
            drive_bbox();
            sample();
            chk("req_ready", 64'(req_ready), 64'(tbl[i].er));
            chk("obj_count", 64'(obj_count), 64'(tbl[i].cnt));
            chk("overflow", 64'(overflow), 64'(tbl[i].ovf));
            chk("busy", 64'(busy), 64'(tbl[i].bsy));
            if (tbl[i].er != '0) begin
                g = 0;
                for (int k = 0; k < NR; k++) if (tbl[i].er[k]) g = k;
                fe_q.push_back('{due: cyc + 1, bbox: bbox_of(g, seq)});
                res_q.push_back('{due: cyc + 1 + LAT, id: RW'(g), idx: OW'(tbl[i].cnt)});
            end
            if (tbl[i].fin) fd_q.push_back(cyc + LAT + 2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Round-robin with all requesters streaming, no req_last: stops at MAX_OBJ with overflow.
        ph[0] = 0;
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(0, 4'hF, 4'h0, 4'(1 << (k % 4)), k == 7, k, 0, 1);
        add(0, 4'hF, 4'h0, 4'h0, 0, 8, 1, 1, 4);
        add(0, 4'hF, 4'h0, 4'h0, 0, 8, 1, 0);
        add(0, 4'h0, 4'h0, 4'h0, 0, 8, 1, 0);
        ph[1] = tbl.size();
        // Last handling: req1 sends two bboxes, others one each, req1 not re-granted after its last.
        add(1, 4'h0, 4'h0, 4'h0, 0, 8, 1, 0);
        add(0, 4'h2, 4'h0, 4'h2, 0, 0, 0, 1);
        add(0, 4'h2, 4'h2, 4'h2, 0, 1, 0, 1);
        add(0, 4'hF, 4'hF, 4'h4, 0, 2, 0, 1);
        add(0, 4'hF, 4'hF, 4'h8, 0, 3, 0, 1);
        add(0, 4'h2, 4'hF, 4'h0, 0, 4, 0, 1);
        add(0, 4'hF, 4'hF, 4'h1, 1, 4, 0, 1);
        add(0, 4'hF, 4'hF, 4'h0, 0, 5, 0, 1, 4);
        add(0, 4'h0, 4'h0, 4'h0, 0, 5, 0, 0);
        ph[2] = tbl.size();
        // Two requesters overflowing; frame_start pulsed mid-RUN must be ignored.
        add(1, 4'h0, 4'h0, 4'h0, 0, 5, 0, 0);
        for (int k = 0; k < 8; k++)
            add(k == 1, 4'h5, 4'h0, (k % 2 == 0) ? 4'h4 : 4'h1, k == 7, k, 0, 1);
        add(0, 4'h5, 4'h0, 4'h0, 0, 8, 1, 1, 4);
        add(0, 4'h5, 4'h0, 4'h0, 0, 8, 1, 0);
        ph[3] = tbl.size();
        // Three stall cycles at frame start, then one bbox from each requester.
        add(1, 4'h0, 4'h0, 4'h0, 0, 8, 1, 0);
        add(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 3);
        add(0, 4'hF, 4'hF, 4'h2, 0, 0, 0, 1);
        add(0, 4'hF, 4'hF, 4'h4, 0, 1, 0, 1);
        add(0, 4'hF, 4'hF, 4'h8, 0, 2, 0, 1);
        add(0, 4'hF, 4'hF, 4'h1, 1, 3, 0, 1);
        add(0, 4'h0, 4'h0, 4'h0, 0, 4, 0, 1, 4);
        add(0, 4'h0, 4'h0, 4'h0, 0, 4, 0, 0);
        ph[4] = tbl.size();
        // Frame interrupted by reset with tags in flight.
        add(1, 4'h0, 4'h0, 4'h0, 0, 4, 0, 0);
        add(0, 4'hF, 4'h0, 4'h2, 0, 0, 0, 1);
        add(0, 4'hF, 4'h0, 4'h4, 0, 1, 0, 1);
        ph[5] = tbl.size();

        reset_N = 1'b1; frame_start = 1'b0; req_valid = '0; req_last = '0; req_bbox = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) reset_N = 1'b0;
            sample();
            check_zero("init_reset");
        end

        run_rows(ph[0], ph[1]);
        run_rows(ph[1], ph[2]);
        run_rows(ph[2], ph[3]);
        run_rows(ph[3], ph[4]);
`ifdef OFLOW_FE_SCHED_PERF_EN
        chk("stall_cycles_frame", 64'(stall_cycles), 64'(3));
`endif
        run_rows(ph[4], ph[5]);
`ifdef OFLOW_FE_SCHED_PERF_EN
        chk("stall_cycles_cleared", 64'(stall_cycles), 64'(0));
`endif

        step();
        purge_future();
        reset_N   = 1'b1;
        req_valid = '0;
        frame_start = 1'b0;
        sample();
        for (int k = 0; k < 3; k++) begin
            step();
            req_valid = 4'hF;
            if (k == 2) reset_N = 1'b0;
            sample();
            check_zero("mid_reset");
        end
        for (int k = 0; k < 6; k++) begin
            step();
            sample();
            chk("idle_req_ready", 64'(req_ready), 64'(0));
        end

        chk("fe_q_empty", 64'(fe_q.size()), 64'(0));
        chk("res_q_empty", 64'(res_q.size()), 64'(0));
        chk("fd_q_empty", 64'(fd_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
